// File: rtl/sd_frame_loader_if.sv
// sd_frame_loader_if: SD read handshake and frame-buffer write port of sd_frame_loader.
//   master (loader): drives sd_rd_out, sd_addr_out, wr_en_out, wr_addr_out, wr_data_out;
//                    samples sd_ready_in, sd_byte_available_in, sd_dout_in.
//   slave  (SD controller / frame buffer side): the mirror image.
interface sd_frame_loader_if #(
  parameter int unsigned WR_ADDR_WIDTH = 17
);
  logic                     sd_ready_in;
  logic                     sd_byte_available_in;
  logic [7:0]               sd_dout_in;
  logic                     sd_rd_out;
  logic [31:0]              sd_addr_out;
  logic                     wr_en_out;
  logic [WR_ADDR_WIDTH-1:0] wr_addr_out;
  logic [7:0]               wr_data_out;

  modport master (
    input  sd_ready_in, sd_byte_available_in, sd_dout_in,
    output sd_rd_out, sd_addr_out, wr_en_out, wr_addr_out, wr_data_out
  );

  modport slave (
    output sd_ready_in, sd_byte_available_in, sd_dout_in,
    input  sd_rd_out, sd_addr_out, wr_en_out, wr_addr_out, wr_data_out
  );
endinterface

// File: rtl/sd_frame_loader.sv
// sd_frame_loader: reads NUM_SECTORS consecutive SD sectors starting at base_sector_in
// and streams every returned byte as a linear write into frame-buffer port A.
//   clk_in, rst_in (sync, active-low)   clock / reset
//   start_in, base_sector_in            one-cycle frame request and first sector index
//   busy_out, done_out, error_out       status: busy, completion pulse, sticky timeout
//   bus (master)                        SD read handshake + frame-buffer write port
module sd_frame_loader #(
  parameter int unsigned SECTOR_BYTES   = 512,
  parameter int unsigned NUM_SECTORS    = 150,
  parameter int unsigned WR_ADDR_WIDTH  = 17,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [31:0] base_sector_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out,
  sd_frame_loader_if.master bus
);

  localparam int unsigned BYTE_W = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
  localparam int unsigned SEC_W  = (NUM_SECTORS > 1) ? $clog2(NUM_SECTORS) : 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SEC_W-1:0]  LAST_SECTOR = SEC_W'(NUM_SECTORS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE   = BYTE_W'(SECTOR_BYTES - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT    = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_ISSUE,
    S_READ_BYTES,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                   state_q, state_d;
  logic [31:0]              base_q, base_d;
  logic [SEC_W-1:0]         sector_q, sector_d;
  logic [BYTE_W-1:0]        byte_q, byte_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     avail_q;
  logic                     rd_q, rd_d;
  logic [31:0]              addr_q, addr_d;
  logic                     wr_en_q, wr_en_d;
  logic [WR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]               wr_data_q, wr_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     start_acc;
  logic                     byte_rise;

  function automatic logic is_busy(input state_t s);
    return (s == S_WAIT_READY) || (s == S_ISSUE) || (s == S_READ_BYTES);
  endfunction

  // A byte is taken only on the 0->1 edge of byte_available, so a held level writes once.
  assign byte_rise = (state_q == S_READ_BYTES) && bus.sd_byte_available_in && !avail_q;

  // Next-state and next-output logic; all outputs are the registered copies of *_d.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    sector_d  = sector_q;
    byte_d    = byte_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_acc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          start_acc = 1'b1;
          base_d    = base_sector_in;
          sector_d  = '0;
          byte_d    = '0;
          state_d   = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (bus.sd_ready_in) begin
          addr_d  = (base_q + 32'(sector_q)) << 9;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.sd_ready_in) state_d = S_READ_BYTES;
      end
      S_READ_BYTES: begin
        if (byte_rise) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.sd_dout_in;
          wr_addr_d = (WR_ADDR_WIDTH'(sector_q) << BYTE_W) | WR_ADDR_WIDTH'(byte_q);
          if (byte_q == LAST_BYTE) begin
            byte_d = '0;
            if (sector_q == LAST_SECTOR) begin
              state_d = S_DONE;
            end else begin
              sector_d = sector_q + SEC_W'(1);
              state_d  = S_WAIT_READY;
            end
          end else begin
            byte_d = byte_q + BYTE_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Watchdog fires only when a busy state made no progress this cycle.
    if (is_busy(state_q) && (state_d == state_q) && !byte_rise && (wd_q == WD_LIMIT)) begin
      state_d = S_ERROR;
    end

    if ((state_d != state_q) || byte_rise || !is_busy(state_q)) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end

    rd_d    = (state_d == S_ISSUE);
    busy_d  = is_busy(state_d);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR) || (error_q && !start_acc);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      sector_q  <= '0;
      byte_q    <= '0;
      wd_q      <= '0;
      avail_q   <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      sector_q  <= sector_d;
      byte_q    <= byte_d;
      wd_q      <= wd_d;
      avail_q   <= bus.sd_byte_available_in;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.sd_rd_out   = rd_q;
  assign bus.sd_addr_out = addr_q;
  assign bus.wr_en_out   = wr_en_q;
  assign bus.wr_addr_out = wr_addr_q;
  assign bus.wr_data_out = wr_data_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign error_out       = error_q;

endmodule

// File: tb/tb_sd_frame_loader.sv
// tb_sd_frame_loader: scripted SD-controller model feeding two loader instances
// (normal and short-timeout) with a scoreboard of expected frame-buffer writes.
module tb_sd_frame_loader;

  localparam int unsigned SB      = 512;
  localparam int unsigned NS      = 2;
  localparam int unsigned AW      = 10;
  localparam int unsigned TO_MAIN = 4096;
  localparam int unsigned TO_WD   = 64;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_sector;
  logic        busy, done, err;
  logic        busy_wd, done_wd, err_wd;

  exp_t        exp_q[$];
  logic [31:0] base_cur;
  int          n_checks;
  int          n_errors;
  int          wr_cnt;
  int          done_cnt;
  int          wd_done_cnt;

  sd_frame_loader_if #(.WR_ADDR_WIDTH(AW)) bus ();
  sd_frame_loader_if #(.WR_ADDR_WIDTH(AW)) bus_wd ();

  assign bus_wd.sd_ready_in          = bus.sd_ready_in;
  assign bus_wd.sd_byte_available_in = bus.sd_byte_available_in;
  assign bus_wd.sd_dout_in           = bus.sd_dout_in;

  sd_frame_loader #(
    .SECTOR_BYTES(SB), .NUM_SECTORS(NS), .WR_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO_MAIN)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .base_sector_in(base_sector),
    .busy_out(busy), .done_out(done), .error_out(err), .bus(bus.master)
  );

  sd_frame_loader #(
    .SECTOR_BYTES(SB), .NUM_SECTORS(NS), .WR_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO_WD)
  ) dut_wd (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .base_sector_in(base_sector),
    .busy_out(busy_wd), .done_out(done_wd), .error_out(err_wd), .bus(bus_wd.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every frame-buffer write must match the oldest byte the SD model sent.
  always @(negedge clk) begin
    exp_t e;
    if (bus.wr_en_out === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_spurious", 64'(bus.wr_addr_out), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.wr_addr_out), 64'(e.addr));
        check("wr_data", 64'(bus.wr_data_out), 64'(e.data));
      end
    end
    if (done === 1'b1) done_cnt++;
    if (done_wd === 1'b1) wd_done_cnt++;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bus.sd_ready_in = 1'b1;
    bus.sd_byte_available_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] base);
    base_sector = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Serves one sector: waits for the read request, acknowledges, sends bytes 0..last_byte.
  task automatic serve_sector(input int sec, input int hold, input int ack, input int last_byte,
                              input int poke_byte, input bit poke_done);
    int          t;
    int          hi;
    exp_t        e;
    logic [31:0] a;
    t = 0;
    while (bus.sd_rd_out !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rd_seen", 64'(bus.sd_rd_out), 64'd1);
    a = (base_cur + 32'(sec)) << 9;
    check("sd_addr", 64'(bus.sd_addr_out), 64'(a));
    hi = 0;
    for (int k = 0; k < ack; k++) begin
      @(negedge clk);
      if (bus.sd_rd_out === 1'b1) hi++;
    end
    check("rd_hold", 64'(hi), 64'(ack));
    bus.sd_ready_in = 1'b0;
    @(negedge clk);
    check("rd_release", 64'(bus.sd_rd_out), 64'd0);
    for (int i = 0; i <= last_byte; i++) begin
      bus.sd_dout_in = 8'(i);
      bus.sd_byte_available_in = 1'b1;
      if (i == poke_byte) start = 1'b1;
      e.addr = AW'(sec * int'(SB) + i);
      e.data = 8'(i);
      exp_q.push_back(e);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        start = 1'b0;
        if (h == 0 && poke_done && i == last_byte) start = 1'b1;
      end
      bus.sd_byte_available_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
    end
    bus.sd_ready_in = 1'b1;
  endtask

  task automatic run_frame(input logic [31:0] base, input int hold, input int ack, input int stall,
                           input int poke_byte, input bit poke_done);
    int hi;
    base_cur = base;
    wr_cnt   = 0;
    done_cnt = 0;
    bus.sd_ready_in = (stall > 0) ? 1'b0 : 1'b1;
    pulse_start(base);
    check("busy_start", 64'(busy), 64'd1);
    check("err_start", 64'(err), 64'd0);
    if (stall > 0) begin
      hi = 0;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        if (bus.sd_rd_out === 1'b1) hi++;
      end
      check("rd_stall", 64'(hi), 64'd0);
      bus.sd_ready_in = 1'b1;
      @(negedge clk);
      check("rd_on_ready", 64'(bus.sd_rd_out), 64'd1);
    end
    for (int s = 0; s < int'(NS); s++) begin
      if (poke_byte >= 0 && s > 0) pulse_start(base + 32'd77);
      serve_sector(s, hold, ack, int'(SB) - 1, (s == 0) ? poke_byte : -1,
                   poke_done && (s == int'(NS) - 1));
    end
    check("busy_after_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("busy_idle", 64'(busy), 64'd0);
    check("done_cnt", 64'(done_cnt), 64'd1);
    check("wr_cnt", 64'(wr_cnt), 64'(NS * SB));
    check("q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;
    wr_cnt = 0;
    done_cnt = 0;
    wd_done_cnt = 0;
    base_cur = '0;
    rst_n = 1'b0;
    start = 1'b0;
    base_sector = '0;
    bus.sd_ready_in = 1'b1;
    bus.sd_byte_available_in = 1'b0;
    bus.sd_dout_in = '0;
    repeat (3) @(negedge clk);
    check("rst_rd", 64'(bus.sd_rd_out), 64'd0);
    check("rst_addr", 64'(bus.sd_addr_out), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, base 10: sector addresses 5120 then 5632.
    run_frame(32'd10, 1, 0, 0, -1, 1'b0);

    // byte_available held 3 cycles; base wraps the 32-bit sector sum.
    do_reset();
    run_frame(32'hFFFF_FFFF, 3, 0, 0, -1, 1'b0);

    // Ready stalled 200 cycles, then held 5 cycles after the request.
    do_reset();
    run_frame(32'd7, 1, 5, 200, -1, 1'b0);

    // Timeout on the short-watchdog instance after byte 100 of sector 0.
    do_reset();
    wd_done_cnt = 0;
    base_cur = 32'd20;
    pulse_start(32'd20);
    serve_sector(0, 1, 0, 100, -1, 1'b0);
    cnt = 1;
    while (err_wd !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("wd_latency", 64'(cnt), 64'(TO_WD));
    repeat (4) @(negedge clk);
    check("err_sticky", 64'(err_wd), 64'd1);
    check("wd_busy", 64'(busy_wd), 64'd0);
    check("wd_no_done", 64'(wd_done_cnt), 64'd0);
    pulse_start(32'd20);
    check("err_clear", 64'(err_wd), 64'd0);
    check("wd_restart_busy", 64'(busy_wd), 64'd1);

    // Reset in the middle of sector 0, then a clean restart.
    do_reset();
    base_cur = 32'd100;
    pulse_start(32'd100);
    serve_sector(0, 1, 0, 300, -1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_rd", 64'(bus.sd_rd_out), 64'd0);
    check("mid_rst_addr", 64'(bus.sd_addr_out), 64'd0);
    check("mid_rst_wr_en", 64'(bus.wr_en_out), 64'd0);
    check("mid_rst_wr_addr", 64'(bus.wr_addr_out), 64'd0);
    check("mid_rst_wr_data", 64'(bus.wr_data_out), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    bus.sd_ready_in = 1'b1;
    exp_q.delete();
    @(negedge clk);
    run_frame(32'd100, 1, 0, 0, -1, 1'b0);

    // start_in while busy (mid-sector and between sectors) and on the DONE cycle.
    do_reset();
    run_frame(32'd3, 1, 0, 0, 50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "simulation time limit");
  end

endmodule
